hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Producer-side companion to the EX-stage operand forwarding mux in the 5-stage MIPS pipeline.
- Shadows the destination, write-enable and load flags of instructions in EX/MEM/WB, one cycle per advance.
- Generates stall/flush controls for load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
- Sits beside the ID stage; its outputs gate the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 255, maximum consecutive mem_busy cycles before the sticky error flag is set; 8-bit range.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_AW  ID source register 1.
- id_rt  input  REG_AW  ID source register 2.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_reg_dest  input  REG_AW  ID destination register.
- id_reg_w_en  input  1  ID instruction writes the register file.
- id_is_load  input  1  ID instruction is a load.
- branch_taken_exe  input  1  branch/jump resolved taken in EX.
- mem_busy  input  1  data memory not ready this cycle.
- stall_pc  output  1  hold PC.
- stall_ifid  output  1  hold IF/ID.
- flush_ifid  output  1  clear IF/ID to bubble.
- flush_idex  output  1  load bubble into ID/EX.
- freeze_all  output  1  hold ID/EX, EX/MEM, MEM/WB; WB write suppressed.
- mem_timeout  output  1  sticky error flag.

Behaviour:
- Shadow stages ex_*, mem_*, wb_*: each holds valid, dest, w_en, load. Reset clears all valid bits to 0.
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- Output priority, highest first: rst, then MEM_WAIT/mem_busy, then redirect, then load-use.
- rst asserted: every output is 0; FSM goes to RUN; timeout counter and flag cleared.
- RUN with mem_busy=1:
  - Same cycle, combinationally: freeze_all=1, stall_pc=1, stall_ifid=1; flushes 0.
  - Shadows hold; FSM goes to MEM_WAIT; counter loads 1.
- MEM_WAIT:
  - Same outputs as above.
  - Counter increments, saturating at 255.
  - counter==MEM_TIMEOUT sets mem_timeout; it stays set until rst.
  - mem_busy=0: return to RUN. That cycle, outputs are evaluated as in RUN.
  - A branch_taken_exe seen during MEM_WAIT is ignored until release. The EX instruction is frozen, so the branch is re-seen in RUN.
- Redirect (RUN, branch_taken_exe & ex_valid):
  - flush_ifid=1 and flush_idex=1 for exactly that cycle; stalls 0.
  - Takes priority over a simultaneous load-use.
- Load-use (RUN, no redirect):
  - Condition: ex_valid & ex_load & ex_w_en & ex_dest!=0 & id_valid & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest)).
  - Response: stall_pc=1, stall_ifid=1, flush_idex=1 for one cycle.
  - Next cycle the load is in MEM, the stall condition is false, and the operand is later forwarded from WB.
- Shadow advance on each clock edge in RUN:
  - wb<=mem, mem<=ex.
  - ex<=bubble (valid=0) if flush_idex, else the id_* fields with valid=id_valid.
- Register 0 never creates a hazard.
- Latency: all stall/flush outputs are combinational in the same cycle as the condition. Only the FSM, shadows, counter and flag are registered.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit output ports perf_load_stalls, perf_redirects, perf_mem_wait_cycles.
  - Each increments once per cycle its condition drives outputs; wrap at 2^32.
  - Cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pipe_pkg: REG_AW, FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1), shadow-stage struct/field widths, MEM_TIMEOUT default.
- One natural sub-module, hazard_shadow_stage: a single valid/dest/w_en/load register with hold and bubble controls, instantiated three times.

Test Plan:
- Reset: rst=1 mid-MEM_WAIT with mem_busy=1 → all outputs 0 immediately; after release with mem_busy=0, FSM in RUN and mem_timeout=0.
- Load-use: lw writing $8 issued, next ID add with rs=$8, uses_rs=1 → one cycle of stall_pc=stall_ifid=flush_idex=1, then 0; same with dest=$0 → no stall.
- Non-load RAW: add writing $9, then sub reading $9 → no stall and no flush.
- Redirect: branch in EX with branch_taken_exe=1 while ID has a load-use on $8 → flush_ifid=flush_idex=1, stall_pc=0, for one cycle.
- Memory wait: mem_busy high 3 cycles → freeze_all=stall_pc=1 for exactly 3 cycles; shadow contents are unchanged across the freeze.
- Timeout: MEM_TIMEOUT=4, mem_busy held 6 cycles → mem_timeout rises on the 4th busy cycle's edge and stays 1 after mem_busy drops, until rst.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the hazard control unit: register address
// width, hazard FSM encoding, the shadow-stage record and the timeout counter.
package cpu_pipe_pkg;

  localparam int REG_AW              = 5;
  localparam int MEM_TIMEOUT_DEFAULT = 255;
  localparam int TMO_W               = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // What the hazard logic needs to remember about an in-flight instruction.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              w_en;
    logic              load;
  } shadow_t;

  // Wait-cycle counter increment that parks at all-ones instead of wrapping.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == {TMO_W{1'b1}}) ? v : v + {{(TMO_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_shadow_stage.sv
// One shadow pipeline stage: tracks valid/dest/w_en/load of the instruction
// occupying the matching real stage. hold keeps the current contents; bubble
// captures the incoming slot as an invalid entry.
module hazard_shadow_stage
  import cpu_pipe_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    hold,
  input  logic    bubble,
  input  shadow_t d,
  output shadow_t q
);

  shadow_t stage_d;
  shadow_t stage_q;

  // Next contents: hold, advance, or advance as a bubble.
  always_comb begin
    // NOTE: default first so every path assigns stage_d and no latch is inferred.
    stage_d = stage_q;
    if (!hold) begin
      stage_d = d;
      if (bubble) stage_d.valid = 1'b0;
    end
  end

  // Stage register; reset leaves an empty (invalid) slot.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment so all stages sample the pre-edge values.
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q = stage_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit for the 5-stage MIPS pipeline. Shadows EX/MEM/WB
// destination info and produces same-cycle stall/flush/freeze controls for
// load-use hazards, taken-branch redirects and data-memory waits, plus a
// sticky memory-timeout flag.
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit event counters.
module hazard_ctrl_unit #(
  parameter int REG_AW      = cpu_pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = cpu_pipe_pkg::MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_reg_dest,
  input  logic              id_reg_w_en,
  input  logic              id_is_load,
  input  logic              branch_taken_exe,
  input  logic              mem_busy,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              freeze_all,
  output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_load_stalls,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_mem_wait_cycles
`endif
);

  import cpu_pipe_pkg::*;

  localparam logic [TMO_W-1:0] TMO_LIMIT = MEM_TIMEOUT[TMO_W-1:0];

  hz_state_e        state_d, state_q;
  logic [TMO_W-1:0] cnt_d, cnt_q;
  logic             tmo_d, tmo_q;

  shadow_t ex_in, ex_q, mem_q, wb_q;
  logic    redirect, load_use, ex_bubble;
  logic    wb_unused;

  // Instruction leaving ID, as the EX shadow will capture it.
  assign ex_in = '{valid: id_valid, dest: id_reg_dest, w_en: id_reg_w_en, load: id_is_load};

  // A busy memory freezes in either state; MEM_WAIT with mem_busy low acts as RUN.
  always_comb begin
    redirect = !mem_busy && branch_taken_exe && ex_q.valid;
    load_use = !mem_busy && !redirect && ex_q.valid && ex_q.load && ex_q.w_en &&
               (ex_q.dest != '0) && id_valid &&
               ((id_uses_rs && (id_rs == ex_q.dest)) ||
                (id_uses_rt && (id_rt == ex_q.dest)));
    ex_bubble = redirect || load_use;
  end

  // Pipeline control outputs, forced low while reset is asserted.
  always_comb begin
    stall_pc    = !rst && (mem_busy || load_use);
    stall_ifid  = !rst && (mem_busy || load_use);
    flush_ifid  = !rst && redirect;
    flush_idex  = !rst && ex_bubble;
    freeze_all  = !rst && mem_busy;
    mem_timeout = tmo_q;
  end

  hazard_shadow_stage u_ex (
    .clk(clk), .rst(rst), .hold(mem_busy), .bubble(ex_bubble), .d(ex_in), .q(ex_q)
  );
  hazard_shadow_stage u_mem (
    .clk(clk), .rst(rst), .hold(mem_busy), .bubble(1'b0), .d(ex_q), .q(mem_q)
  );
  hazard_shadow_stage u_wb (
    .clk(clk), .rst(rst), .hold(mem_busy), .bubble(1'b0), .d(mem_q), .q(wb_q)
  );

  // WB shadow completes the pipeline picture; no hazard decision reads it.
  assign wb_unused = ^wb_q;

  // Wait FSM next state, consecutive-busy counter and sticky timeout flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          cnt_d   = {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (mem_busy && (cnt_d == TMO_LIMIT)) tmo_d = 1'b1;
  end

  // FSM, counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_ld_d, perf_ld_q, perf_rd_d, perf_rd_q, perf_mw_d, perf_mw_q;

  // Event counters, one increment per cycle the event drives the outputs.
  always_comb begin
    perf_ld_d = perf_ld_q + {31'd0, load_use};
    perf_rd_d = perf_rd_q + {31'd0, redirect};
    perf_mw_d = perf_mw_q + {31'd0, mem_busy};
  end

  // Event counter registers, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ld_q <= '0;
      perf_rd_q <= '0;
      perf_mw_q <= '0;
    end else begin
      perf_ld_q <= perf_ld_d;
      perf_rd_q <= perf_rd_d;
      perf_mw_q <= perf_mw_d;
    end
  end

  assign perf_load_stalls     = perf_ld_q;
  assign perf_redirects       = perf_rd_q;
  assign perf_mem_wait_cycles = perf_mw_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios followed by
// random traffic, all compared against an instruction-level reference model.
module tb_hazard_ctrl_unit;

  localparam int TMO = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       wen;
    logic       load;
  } instr_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wen;
    logic       load;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_reg_dest = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_reg_w_en = 1'b0, id_is_load = 1'b0;
  logic       branch_taken_exe = 1'b0, mem_busy = 1'b0;
  logic       stall_pc, stall_ifid, flush_ifid, flush_idex, freeze_all, mem_timeout;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the instructions in EX, MEM, WB, plus busy-run length.
  slot_t pipe [3];
  int    busy_run;
  logic  tmo_flag;

  hazard_ctrl_unit #(.REG_AW(5), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_dest(id_reg_dest), .id_reg_w_en(id_reg_w_en), .id_is_load(id_is_load),
    .branch_taken_exe(branch_taken_exe), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .freeze_all(freeze_all), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk_nop();
    return '0;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] dest, input logic [4:0] base);
    instr_t i = '0;
    i.valid = 1'b1; i.rs = base; i.urs = 1'b1; i.dest = dest; i.wen = 1'b1; i.load = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_alu(input logic [4:0] dest, input logic [4:0] a, input logic [4:0] b);
    instr_t i = '0;
    i.valid = 1'b1; i.rs = a; i.rt = b; i.urs = 1'b1; i.urt = 1'b1; i.dest = dest; i.wen = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_rd_rs(input logic [4:0] dest, input logic [4:0] a);
    instr_t i = mk_alu(dest, a, 5'd0);
    i.urt = 1'b0;
    return i;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    busy_run = 0;
    tmo_flag = 1'b0;
  endtask

  // One clock cycle: drive ID/branch/busy just after a falling edge, check the
  // same-cycle outputs, then advance the model across the rising edge.
  task automatic cycle(input instr_t id, input logic br, input logic busy, input string tag);
    logic e_redir, e_lu, e_fz;
    logic src_hit;
    id_valid = id.valid; id_rs = id.rs; id_rt = id.rt;
    id_uses_rs = id.urs; id_uses_rt = id.urt;
    id_reg_dest = id.dest; id_reg_w_en = id.wen; id_is_load = id.load;
    branch_taken_exe = br; mem_busy = busy;
    #1;
    e_fz    = busy;
    e_redir = !busy && br && pipe[0].valid;
    src_hit = (id.urs && id.rs == pipe[0].dest) || (id.urt && id.rt == pipe[0].dest);
    e_lu    = !busy && !e_redir && pipe[0].valid && pipe[0].load && pipe[0].wen &&
              pipe[0].dest != 5'd0 && id.valid && src_hit;
    check({tag, ".stall_pc"},    stall_pc,    e_fz | e_lu);
    check({tag, ".stall_ifid"},  stall_ifid,  e_fz | e_lu);
    check({tag, ".flush_ifid"},  flush_ifid,  e_redir);
    check({tag, ".flush_idex"},  flush_idex,  e_redir | e_lu);
    check({tag, ".freeze_all"},  freeze_all,  e_fz);
    check({tag, ".mem_timeout"}, mem_timeout, tmo_flag);
    @(posedge clk);
    if (busy) begin
      busy_run++;
      if (busy_run == TMO) tmo_flag = 1'b1;
    end else begin
      busy_run = 0;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e_redir || e_lu) pipe[0] = '0;
      else pipe[0] = '{valid: id.valid, dest: id.dest, wen: id.wen, load: id.load};
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse with busy/branch/ID traffic still applied.
  task automatic do_reset(input logic busy, input string tag);
    mem_busy = busy; branch_taken_exe = 1'b1; id_valid = 1'b1;
    rst = 1'b1;
    #1;
    check({tag, ".stall_pc"},    stall_pc,    1'b0);
    check({tag, ".stall_ifid"},  stall_ifid,  1'b0);
    check({tag, ".flush_ifid"},  flush_ifid,  1'b0);
    check({tag, ".flush_idex"},  flush_idex,  1'b0);
    check({tag, ".freeze_all"},  freeze_all,  1'b0);
    check({tag, ".mem_timeout"}, mem_timeout, 1'b0);
    model_clear();
    @(negedge clk);
    rst = 1'b0; mem_busy = 1'b0; branch_taken_exe = 1'b0; id_valid = 1'b0;
  endtask

  initial begin
    instr_t r;
    model_clear();
    @(negedge clk);
    do_reset(1'b1, "por");

    // Load-use on $8: one stall cycle, then the dependent add proceeds.
    cycle(mk_lw(5'd8, 5'd1),       1'b0, 1'b0, "lu_lw");
    cycle(mk_rd_rs(5'd10, 5'd8),   1'b0, 1'b0, "lu_stall");
    cycle(mk_rd_rs(5'd10, 5'd8),   1'b0, 1'b0, "lu_after");
    // Load to $0 never stalls.
    cycle(mk_lw(5'd0, 5'd1),       1'b0, 1'b0, "z_lw");
    cycle(mk_rd_rs(5'd10, 5'd0),   1'b0, 1'b0, "z_use");
    // Non-load RAW on $9: forwarding handles it, no stall.
    cycle(mk_alu(5'd9, 5'd2, 5'd3),   1'b0, 1'b0, "raw_add");
    cycle(mk_alu(5'd11, 5'd9, 5'd9),  1'b0, 1'b0, "raw_sub");
    // Redirect beats a simultaneous load-use on $8.
    cycle(mk_lw(5'd8, 5'd1),       1'b0, 1'b0, "rd_lw");
    cycle(mk_rd_rs(5'd10, 5'd8),   1'b1, 1'b0, "rd_br");
    cycle(mk_nop(),                1'b0, 1'b0, "rd_after");
    // Memory wait for 3 cycles with a pending load-use; EX shadow must survive.
    cycle(mk_lw(5'd8, 5'd1),       1'b0, 1'b0, "mw_lw");
    for (int k = 0; k < 3; k++) cycle(mk_rd_rs(5'd10, 5'd8), 1'b1, 1'b1, "mw_busy");
    cycle(mk_rd_rs(5'd10, 5'd8),   1'b0, 1'b0, "mw_rel");
    cycle(mk_rd_rs(5'd10, 5'd8),   1'b0, 1'b0, "mw_go");
    // Timeout: 6 busy cycles, flag must stay set afterwards.
    for (int k = 0; k < 6; k++) cycle(mk_nop(), 1'b0, 1'b1, "tmo_busy");
    for (int k = 0; k < 3; k++) cycle(mk_nop(), 1'b0, 1'b0, "tmo_hold");
    // Reset in the middle of a memory wait.
    cycle(mk_nop(), 1'b0, 1'b1, "rw_busy");
    cycle(mk_nop(), 1'b0, 1'b1, "rw_busy");
    do_reset(1'b1, "rst_mw");
    cycle(mk_nop(), 1'b0, 1'b0, "rst_post");

    // Random traffic on a small register window so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1) == 1, "rnd_rst");
      end else begin
        r.valid = ($urandom_range(0, 7) != 0);
        r.rs    = 5'($urandom_range(0, 3));
        r.rt    = 5'($urandom_range(0, 3));
        r.urs   = $urandom_range(0, 1) == 1;
        r.urt   = $urandom_range(0, 1) == 1;
        r.dest  = 5'($urandom_range(0, 3));
        r.wen   = ($urandom_range(0, 3) != 0);
        r.load  = $urandom_range(0, 1) == 1;
        cycle(r, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
